// File: rtl/dvs_event_scheduler.sv
// Round-robin scheduler for two DVS requesters sharing one preprocessor.
// Owns the microsecond timestamp and buffers passed events toward RAVENS.
package dvs_ravens_pkg;
    localparam int DVS_X_ADDR_BITS   = 8;
    localparam int DVS_Y_ADDR_BITS   = 8;
    localparam int TIMESTAMP_US_BITS = 8;
    localparam int EVENT_BITS        =
        DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + TIMESTAMP_US_BITS;
endpackage

module dvs_event_scheduler
    import dvs_ravens_pkg::*;
#(
    parameter int CLKS_PER_US = 100,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_BITS    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  logic [1:0][DVS_X_ADDR_BITS-1:0]     req_x,
    input  logic [1:0][DVS_Y_ADDR_BITS-1:0]     req_y,
    input  logic [1:0]                          req_polarity,
    output logic [DVS_X_ADDR_BITS-1:0]          pp_event_x,
    output logic [DVS_Y_ADDR_BITS-1:0]          pp_event_y,
    output logic [TIMESTAMP_US_BITS-1:0]        pp_event_timestamp,
    output logic                                pp_event_polarity,
    input  logic [EVENT_BITS-1:0]               pp_preprocessed_event,
    input  logic                                pp_event_filtered,
    output logic [EVENT_BITS-1:0]               out_event,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic [CNT_BITS-1:0]                 filtered_count,
    output logic [CNT_BITS-1:0]                 passed_count,
    output logic                                busy
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        STALL
    } state_t;

    state_t                       state;
    logic                         last_grant;
    logic [PW-1:0]                presc;
    logic [TIMESTAMP_US_BITS-1:0] us_count;
    logic                         grant_vld;
    logic                         grant_idx;
    logic [EVENT_BITS-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic                         full;
    logic                         push;
    logic                         pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            us_count <= '0;
        end else if (presc == PW'(CLKS_PER_US - 1)) begin
            presc    <= '0;
            us_count <= us_count + TIMESTAMP_US_BITS'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Tie goes to the requester not granted last time.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (!rst && enable && state == IDLE) begin
            unique case (1'b1)
                (req_valid == 2'b01): begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b0;
                end
                (req_valid == 2'b10): begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b1;
                end
                (req_valid == 2'b11): begin
                    grant_vld = 1'b1;
                    grant_idx = ~last_grant;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = grant_vld ? (2'b01 << grant_idx) : 2'b00;

    assign full = (fifo_level == LW'(FIFO_DEPTH));
    assign push = !full &&
                  ((state == EVAL && !pp_event_filtered) ||
                   state == STALL);
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            pp_event_x         <= '0;
            pp_event_y         <= '0;
            pp_event_timestamp <= '0;
            pp_event_polarity  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state              <= EVAL;
                        last_grant         <= grant_idx;
                        pp_event_x         <= req_x[grant_idx];
                        pp_event_y         <= req_y[grant_idx];
                        pp_event_polarity  <= req_polarity[grant_idx];
                        pp_event_timestamp <= us_count;
                    end
                end
                EVAL: begin
                    if (!pp_event_filtered && full) state <= STALL;
                    else                            state <= IDLE;
                end
                STALL: begin
                    if (!full) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pp_preprocessed_event;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (pop && !push) fifo_level <= fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtered_count <= '0;
            passed_count   <= '0;
        end else begin
            if (state == EVAL && pp_event_filtered &&
                filtered_count != '1)
                filtered_count <= filtered_count + CNT_BITS'(1);
            if (push && passed_count != '1)
                passed_count <= passed_count + CNT_BITS'(1);
        end
    end

    assign out_event = mem[rd_ptr];
    assign out_valid = (fifo_level != '0);
    assign busy      = (state != IDLE);

endmodule

// File: doc/dvs_event_scheduler.md
# dvs_event_scheduler

Sequences the shared `dvs_event_preprocessor` datapath between two DVS event requesters. It owns the microsecond timestamp counter and arbitrates round-robin between the requesters. It presents one captured event at a time to the preprocessor and buffers unfiltered preprocessed events in an output FIFO toward the RAVENS interface with valid/ready backpressure. It sits between the camera readout front-ends and the RAVENS event sink.

## Interface
Widths `DVS_X_ADDR_BITS`, `DVS_Y_ADDR_BITS`, `TIMESTAMP_US_BITS` and `EVENT_BITS` come from `dvs_ravens_pkg`.

Parameters:
- `CLKS_PER_US`, default 100: clk cycles per timestamp microsecond; must be ≥ 1.
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of two, ≥ 2.
- `CNT_BITS`, default 16: width of the statistics counters.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: when low, no new grants are issued.
- `req_valid[1:0]` in 2: requester i has an event.
- `req_ready[1:0]` out 2: requester i's event is accepted this cycle.
- `req_x[1:0]` in 2×`DVS_X_ADDR_BITS`; `req_y[1:0]` in 2×`DVS_Y_ADDR_BITS`; `req_polarity[1:0]` in 2: per-requester event fields.
- `pp_event_x` out `DVS_X_ADDR_BITS`; `pp_event_y` out `DVS_Y_ADDR_BITS`; `pp_event_timestamp` out `TIMESTAMP_US_BITS`; `pp_event_polarity` out 1: registered drive to the preprocessor.
- `pp_preprocessed_event` in `EVENT_BITS`; `pp_event_filtered` in 1: combinational result from the preprocessor.
- `out_event` out `EVENT_BITS`; `out_valid` out 1; `out_ready` in 1: FIFO head toward RAVENS.
- `fifo_level` out $clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `filtered_count` out `CNT_BITS`; `passed_count` out `CNT_BITS`: saturating event counters.
- `busy` out 1: state ≠ IDLE.

## Operation
- **Timestamp.** A prescaler counts 0..`CLKS_PER_US`−1. When it wraps, `us_count` increments and wraps modulo 2^`TIMESTAMP_US_BITS`. Both counters run regardless of `enable`.
- **Arbitration** (IDLE only, `enable` high):
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one ≠ `last_grant`.
  - `last_grant` updates on each grant and resets to 1, so requester 0 wins the first tie.
  - `req_ready[i]` is combinational and high only for the granted requester in that cycle.
- **Capture.** On the grant edge, `pp_event_*` registers load the granted x, y and polarity, plus `us_count` as it stood in the grant cycle (pre-increment if a tick coincides).
- **FSM:**
  - IDLE: grant → EVAL; otherwise stay.
  - EVAL, `pp_event_filtered`=1: `filtered_count`++ → IDLE.
  - EVAL, not filtered, FIFO not full: push `pp_preprocessed_event`, `passed_count`++ → IDLE.
  - EVAL, not filtered, FIFO full: → STALL.
  - STALL: hold the `pp_event_*` registers; when FIFO not full, push, `passed_count`++ → IDLE.
- **FIFO.**
  - "Full" is evaluated before the same-cycle pop: no push while full, even if `out_ready` is high.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave `fifo_level` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `out_event` is the head entry; `out_valid` = (`fifo_level` ≠ 0).
- **Counters** saturate at 2^`CNT_BITS`−1.
- **`enable` dropped** mid-operation: the in-flight event completes EVAL/STALL normally, and no further grants are issued.
- **Reset** (any time): all state clears and any in-flight or buffered event is discarded.
  - Reset values: FSM=IDLE, `req_ready`=0, all `pp_event_*`=0, `us_count`=0, prescaler=0, FIFO empty, `out_valid`=0, `out_event`=0, `fifo_level`=0, counters=0, `busy`=0, `last_grant`=1.

## Timing
- Maximum throughput is 1 event per 2 cycles: grant in IDLE, decide in EVAL.
- Latency with the FIFO empty and not filtered:
  - grant in cycle N;
  - `pp_event_*` valid in N+1 (EVAL), push at the end of N+1;
  - `out_valid`=1 in N+2.
- Filtered events produce no output. `filtered_count` updates at the end of EVAL.
- STALL persists while full. The push occurs in the first cycle after a pop makes room (that pop is seen as `fifo_level` < `FIFO_DEPTH` on the next cycle).
- The path `pp_event_*` → preprocessor → `pp_event_filtered`/`pp_preprocessed_event` is single-cycle combinational within EVAL/STALL.

## Test plan
- **Single pass.** `CLKS_PER_US`=4. After reset, wait 10 cycles, then req0 x=5, y=7, pol=1. Required: `req_ready[0]` high for 1 cycle; `out_valid` exactly 2 cycles later; `out_event`={5,7,1,ts=2}; `passed_count`=1.
- **Filtering.**
  - req1 with pol=0 → no `out_valid`; `filtered_count`=1; FSM back in IDLE 2 cycles after the grant.
  - req1 with x=150, pol=1 → same filtered behaviour.
- **Round-robin.** Both requesters continuously valid for 8 grants → grants alternate 0,1,0,1,…, each 2 cycles apart; counts 4/4.
- **Backpressure.**
  - `out_ready`=0 with 5 passing events at `FIFO_DEPTH`=4: `fifo_level`=4, FSM=STALL, `req_ready`=0, `busy`=1.
  - Then `out_ready`=1 for 1 cycle: the stalled event is pushed the following cycle; output order is preserved.
- **Timestamp wrap.** With `TIMESTAMP_US_BITS` at its package value, preload by running to `us_count`=max, then grant in the tick cycle → event carries max; the next event carries 0.
- **Async reset mid-STALL.** Assert `rst` asynchronously while in STALL with a full FIFO → `out_valid`, `fifo_level` and counters go to 0 immediately; after release, the first tie grants requester 0.
